// File: rtl/regfile_sb.sv
// 2-read/1-write register file with per-register pending-write scoreboard; RF_WB_BYPASS_EN adds same-cycle WB forwarding.
// Latency: reads/busy combinational, writes and counter updates visible the cycle after the edge.
// Backpressure: none; a saturated counter holds and raises sticky sb_ovf instead of stalling.
module regfile_sb #(
    parameter int                   DATA_W   = 32,
    parameter int                   ADDR_W   = 4,
    parameter int                   NUM_REGS = 15,
    parameter logic [NUM_REGS-1:0]  WP_MASK  = '0,
    parameter int                   CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic              src1_busy,
    output logic              src2_busy,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              writeBackEn,
    input  logic [ADDR_W-1:0] Dest_wb,
    input  logic [DATA_W-1:0] Result_WB,
    output logic              sb_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [CNT_W-1:0]    cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] iss_hit;
    logic                ovf_hit;

    // Per-register decode keeps out-of-range indices from ever touching state.
    always_comb begin
        wb_hit  = '0;
        iss_hit = '0;
        ovf_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wb_hit[i]  = writeBackEn && (Dest_wb == ADDR_W'(i));
            iss_hit[i] = issue_en && (issue_dest == ADDR_W'(i));
            if (iss_hit[i] && !wb_hit[i] && (cnt[i] == CNT_MAX))
                ovf_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            sb_ovf <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb_hit[i] && !WP_MASK[i])
                    regs[i] <= Result_WB;
                // Write-backs retire even to protected registers, so the counter still drops.
                if (flush) begin
                    cnt[i] <= '0;
                end else if (iss_hit[i] && !wb_hit[i]) begin
                    if (cnt[i] != CNT_MAX)
                        cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (wb_hit[i] && !iss_hit[i]) begin
                    if (cnt[i] != '0)
                        cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
            if (!flush && ovf_hit)
                sb_ovf <= 1'b1;
        end
    end

    always_comb begin
        reg1      = '0;
        reg2      = '0;
        src1_busy = 1'b0;
        src2_busy = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (src1 == ADDR_W'(i)) begin
                reg1      = regs[i];
                src1_busy = (cnt[i] != '0);
`ifdef RF_WB_BYPASS_EN
                if (rst && wb_hit[i] && !WP_MASK[i])
                    reg1 = Result_WB;
                if (rst && wb_hit[i] && !iss_hit[i] && (cnt[i] == CNT_W'(1)))
                    src1_busy = 1'b0;
`endif
            end
            if (src2 == ADDR_W'(i)) begin
                reg2      = regs[i];
                src2_busy = (cnt[i] != '0);
`ifdef RF_WB_BYPASS_EN
                if (rst && wb_hit[i] && !WP_MASK[i])
                    reg2 = Result_WB;
                if (rst && wb_hit[i] && !iss_hit[i] && (cnt[i] == CNT_W'(1)))
                    src2_busy = 1'b0;
`endif
            end
        end
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU register file.
- N-entry, 2-read / 1-write register file with per-register outstanding-write scoreboard (pending counters) for ID-stage hazard detection.
- Sits between ID (reads, issue) and WB (write-back); hazard unit consumes busy flags.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 4, register index width
- NUM_REGS, 15, implemented registers (index 0..NUM_REGS-1, NUM_REGS <= 2**ADDR_W)
- WP_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i write-protected
- CNT_W, 2, width of per-register pending-write counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- flush  in  1  clear all pending counters (pipeline flush)
- src1  in  ADDR_W  read index A
- src2  in  ADDR_W  read index B
- reg1  out  DATA_W  read data A
- reg2  out  DATA_W  read data B
- src1_busy  out  1  src1 has outstanding write
- src2_busy  out  1  src2 has outstanding write
- issue_en  in  1  instruction with destination leaves ID this cycle
- issue_dest  in  ADDR_W  destination of issuing instruction
- writeBackEn  in  1  write-back valid
- Dest_wb  in  ADDR_W  write-back destination
- Result_WB  in  DATA_W  write-back data
- sb_ovf  out  1  sticky: issue hit saturated counter

Behaviour:
- Reset (rst=0, async): all registers = 0, all counters = 0, sb_ovf = 0; outputs reg1/reg2 = 0, busy = 0 while held. Reset mid-operation discards pending writes; first edge after release behaves normally.
- Reads combinational: reg1 = Reg[src1], reg2 = Reg[src2]. Index >= NUM_REGS reads 0, busy = 0.
- Write on rising clk when writeBackEn=1, Dest_wb < NUM_REGS, and WP_MASK[Dest_wb]=0. Otherwise the register is unchanged. Write visible on reads the cycle after (without the optional feature).
- Pending counter per register, updated on rising clk:
  - issue_en only → +1
  - writeBackEn only → -1
  - both to same index → unchanged
  - both to different indices → each updated independently
- Issue to a counter at 2**CNT_W-1 → counter holds, sb_ovf set (sticky until reset).
- Write-back to a counter at 0 → counter holds at 0 (no underflow). The data write still occurs.
- Counters decrement on write-back even for write-protected indices (the instruction retired). Indices >= NUM_REGS are ignored by the scoreboard.
- srcN_busy = (counter[srcN] != 0), combinational.
- flush=1 at rising edge: all counters ← 0. Issue and write-back in that cycle are ignored for counters. Data write still happens.

Optional Feature:
- Macro RF_WB_BYPASS_EN.
- Defined:
  - If writeBackEn=1 and Dest_wb == srcN (writable, in range), regN = Result_WB combinationally in the same cycle.
  - srcN_busy is masked to 0 when the counter == 1 and write-back to srcN is occurring (without a same-index issue).
- Undefined: no forwarding; reads and busy reflect registered state only.

Test Plan:
- Assert rst=0 mid-run after writing R3=0xDEADBEEF and issuing R5 → reg1(src1=3)=0, src1_busy(src1=5)=0, sb_ovf=0; after release all reads 0.
- Write R7=0x12345678 (WP_MASK=0) → next cycle reg2(src2=7)=0x12345678. With WP_MASK bit 7 set, R7 stays 0.
- Issue R4 twice, then one WB R4 → busy stays 1; second WB → busy 0; third WB → counter stays 0, no underflow.
- Same-cycle issue R2 + WB R2 with counter=1 → counter stays 1, busy=1, R2 holds Result_WB.
- CNT_W=2: issue R9 four times → counter 3, sb_ovf=1 on fourth issue; flush → all busy 0, sb_ovf stays 1.
- RF_WB_BYPASS_EN: WB R6=0xA5A5A5A5 with src1=6, counter=1 → same cycle reg1=0xA5A5A5A5, src1_busy=0. Without the macro → reg1=old value, src1_busy=1.
